// File: rtl/as5600_speed_estimator.sv
// Speed estimator for the AS5600 mechanical angle: samples the angle on a fixed tick,
// forms wrap-aware glitch-filtered deltas and reports their windowed sum as signed speed.
module as5600_speed_estimator #(
  parameter int SAMPLE_DIV    = 40000,
  parameter int WINDOW_LOG2   = 4,
  parameter int GLITCH_LIMIT  = 512,
  parameter int STALL_WINDOWS = 8
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_en,
  input  logic [11:0]        I_angle_mec,
  output logic signed [15:0] O_speed,
  output logic               O_speed_valid,
  output logic               O_dir,
  output logic               O_stall,
  output logic [7:0]         O_glitch_cnt
);

  localparam int                   DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [4:0]           WIN_LAST  = 5'((1 << WINDOW_LOG2) - 1);
  localparam int                   STALL_W   = $clog2(STALL_WINDOWS + 1);
  localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_WINDOWS);
  localparam logic signed [12:0]   LIM_POS   = 13'(GLITCH_LIMIT);
  localparam logic signed [12:0]   LIM_NEG   = 13'(-GLITCH_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [DIV_W-1:0]          div_r;
  logic                      tick_s;
  logic [11:0]               prev_angle_r;
  logic signed [11:0]        last_delta_r;
  logic [1:0]                rej_r;
  logic signed [15:0]        sum_r;
  logic [4:0]                smp_cnt_r;
  logic [STALL_W-1:0]        zero_cnt_r;
  logic signed [11:0]        raw_s;
  logic signed [12:0]        raw_ext_s;
  logic                      accept_s;
  logic signed [11:0]        delta_s;
  logic signed [15:0]        delta_ext_s;
  logic signed [15:0]        sum_nxt_s;
  logic [STALL_W-1:0]        zero_nxt_s;

  assign tick_s = I_en && (div_r == DIV_LAST);

  // Sample divider, parked at zero while disabled
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      div_r <= '0;
    end else if (!I_en || (div_r == DIV_LAST)) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: disable forces IDLE from anywhere
  always_comb begin
    state_nxt_s = state_r;
    if (!I_en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = PRIME;
        PRIME:   if (tick_s) state_nxt_s = RUN; else state_nxt_s = PRIME;
        RUN:     state_nxt_s = RUN;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Delta selection: the modulo-4096 difference read as signed handles the 4095/0 wrap
  always_comb begin
    raw_s     = signed'(I_angle_mec - prev_angle_r);
    raw_ext_s = {raw_s[11], raw_s};
    accept_s  = ((raw_ext_s <= LIM_POS) && (raw_ext_s >= LIM_NEG)) || (rej_r >= 2'd2);
    if (accept_s) begin
      delta_s = raw_s;
    end else begin
      delta_s = last_delta_r;
    end
    delta_ext_s = {{4{delta_s[11]}}, delta_s};
    sum_nxt_s   = sum_r + delta_ext_s;
    if (sum_nxt_s != 16'sd0) begin
      zero_nxt_s = '0;
    end else if (zero_cnt_r == STALL_MAX) begin
      zero_nxt_s = STALL_MAX;
    end else begin
      zero_nxt_s = zero_cnt_r + STALL_W'(1);
    end
  end

  // Filter, window accumulator and registered outputs
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      prev_angle_r  <= 12'd0;
      last_delta_r  <= 12'sd0;
      rej_r         <= 2'd0;
      sum_r         <= 16'sd0;
      smp_cnt_r     <= 5'd0;
      zero_cnt_r    <= '0;
      O_speed       <= 16'sd0;
      O_speed_valid <= 1'b0;
      O_dir         <= 1'b0;
      O_stall       <= 1'b0;
      O_glitch_cnt  <= 8'd0;
    end else begin
      O_speed_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          last_delta_r <= 12'sd0;
          rej_r        <= 2'd0;
          sum_r        <= 16'sd0;
          smp_cnt_r    <= 5'd0;
          zero_cnt_r   <= '0;
          O_stall      <= 1'b0;
        end
        PRIME: begin
          if (tick_s) begin
            prev_angle_r <= I_angle_mec;
            last_delta_r <= 12'sd0;
            rej_r        <= 2'd0;
          end
        end
        RUN: begin
          if (tick_s) begin
            prev_angle_r <= I_angle_mec;
            if (accept_s) begin
              last_delta_r <= raw_s;
              rej_r        <= 2'd0;
            end else begin
              rej_r <= rej_r + 2'd1;
              if (O_glitch_cnt != 8'hFF) begin
                O_glitch_cnt <= O_glitch_cnt + 8'd1;
              end
            end
            if (smp_cnt_r == WIN_LAST) begin
              O_speed       <= sum_nxt_s;
              O_speed_valid <= 1'b1;
              O_dir         <= sum_nxt_s[15];
              zero_cnt_r    <= zero_nxt_s;
              O_stall       <= (zero_nxt_s == STALL_MAX);
              sum_r         <= 16'sd0;
              smp_cnt_r     <= 5'd0;
            end else begin
              sum_r     <= sum_nxt_s;
              smp_cnt_r <= smp_cnt_r + 5'd1;
            end
          end
        end
        default: begin
          sum_r     <= 16'sd0;
          smp_cnt_r <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_as5600_speed_estimator.sv
// Scoreboard bench for as5600_speed_estimator: a behavioural model pushes expected
// window results as samples are driven; a monitor pops them when the strobe fires.
module tb_as5600_speed_estimator;

  localparam int SDIV   = 8;
  localparam int WL2    = 2;
  localparam int WIN    = 4;
  localparam int GLIM   = 512;
  localparam int STALLW = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [11:0]        angle = 12'd0;
  logic signed [15:0] speed;
  logic               speed_valid;
  logic               dir;
  logic               stall;
  logic [7:0]         glitch_cnt;

  typedef struct {
    int speed;
    int dir;
    int stall;
    int glitch;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   obs_speed = 0;

  int m_primed = 0, m_prev = 0, m_last = 0, m_rej = 0;
  int m_sum = 0, m_cnt = 0, m_glitch = 0, m_zero = 0;

  always #5 clk = ~clk;

  as5600_speed_estimator #(
    .SAMPLE_DIV(SDIV), .WINDOW_LOG2(WL2), .GLITCH_LIMIT(GLIM), .STALL_WINDOWS(STALLW)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_angle_mec(angle),
    .O_speed(speed), .O_speed_valid(speed_valid), .O_dir(dir),
    .O_stall(stall), .O_glitch_cnt(glitch_cnt)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Strobe monitor, sampled just after the clock edge
  always @(posedge clk) begin
    #1;
    if (rst_n && speed_valid) begin
      check_eq("strobe_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_eq("speed", int'(speed), mon_e.speed);
        check_eq("dir", int'(dir), mon_e.dir);
        check_eq("stall", int'(stall), mon_e.stall);
        check_eq("glitch_cnt", int'(glitch_cnt), mon_e.glitch);
      end
      obs_speed = int'(speed);
    end
  end

  task automatic model_idle();
    m_primed = 0; m_last = 0; m_rej = 0; m_sum = 0; m_cnt = 0; m_zero = 0;
  endtask

  // Drive one sample (called at a negedge); returns at the negedge after its capture edge
  task automatic drive_sample(input int a);
    int   raw;
    int   d;
    exp_t e;
    angle = 12'(a);
    if (m_primed == 0) begin
      m_prev = a; m_last = 0; m_rej = 0; m_primed = 1;
    end else begin
      raw = (a - m_prev) & 4095;
      if (raw > 2047) raw = raw - 4096;
      m_prev = a;
      if ((raw > GLIM || raw < -GLIM) && m_rej < 2) begin
        d = m_last; m_rej++;
        if (m_glitch < 255) m_glitch++;
      end else begin
        d = raw; m_last = raw; m_rej = 0;
      end
      m_sum += d;
      m_cnt++;
      if (m_cnt == WIN) begin
        if (m_sum == 0) m_zero = (m_zero < STALLW) ? m_zero + 1 : m_zero;
        else m_zero = 0;
        e.speed = m_sum; e.dir = (m_sum < 0) ? 1 : 0;
        e.stall = (m_zero == STALLW) ? 1 : 0; e.glitch = m_glitch;
        exp_q.push_back(e);
        m_sum = 0; m_cnt = 0;
      end
    end
    repeat (SDIV) @(posedge clk);
    @(negedge clk);
    check_eq("latency", exp_q.size(), 0);
  endtask

  task automatic start_run(input int a);
    @(negedge clk);
    en = 1'b1;
    drive_sample(a);
  endtask

  task automatic stop_run();
    en = 1'b0;
    model_idle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_speed", int'(speed), 0);
    check_eq("rst_valid", int'(speed_valid), 0);
    check_eq("rst_stall", int'(stall), 0);
    check_eq("rst_glitch", int'(glitch_cnt), 0);
    rst_n = 1'b1;

    // Ramp +10 per sample
    start_run(100);
    for (int i = 1; i <= 4; i++) drive_sample(100 + 10 * i);
    check_eq("ramp_speed", obs_speed, 40);
    check_eq("ramp_dir", int'(dir), 0);
    for (int i = 5; i <= 10; i++) drive_sample(100 + 10 * i);
    check_eq("ramp_speed2", obs_speed, 40);
    stop_run();
    check_eq("drop_hold_speed", int'(speed), 40);
    start_run(300);
    for (int i = 1; i <= 4; i++) drive_sample(300 + 5 * i);
    check_eq("restart_speed", obs_speed, 20);
    stop_run();

    // Wrap across zero, forwards then backwards
    start_run(4090);
    drive_sample(4095); drive_sample(4); drive_sample(9); drive_sample(14);
    check_eq("wrap_fwd", obs_speed, 20);
    drive_sample(9); drive_sample(4); drive_sample(4095); drive_sample(4090);
    check_eq("wrap_rev", obs_speed, -20);
    check_eq("wrap_rev_dir", int'(dir), 1);
    stop_run();

    // Single-sample glitch and its return
    start_run(200);
    drive_sample(210); drive_sample(1720); drive_sample(230); drive_sample(240);
    check_eq("glitch_speed", obs_speed, 40);
    check_eq("glitch_count", int'(glitch_cnt), 2);
    stop_run();

    // Genuine jump: three consecutive over-limit steps
    start_run(100);
    drive_sample(1100); drive_sample(2100); drive_sample(3100); drive_sample(3100);
    check_eq("jump_speed", obs_speed, 1000);
    check_eq("jump_glitch", int'(glitch_cnt), 4);
    for (int i = 0; i < 4; i++) drive_sample(3100);
    check_eq("jump_after", obs_speed, 0);
    stop_run();

    // Reset mid-window
    start_run(50);
    drive_sample(60); drive_sample(70);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    model_idle();
    m_glitch = 0;
    #1;
    check_eq("midrst_speed", int'(speed), 0);
    check_eq("midrst_dir", int'(dir), 0);
    check_eq("midrst_glitch", int'(glitch_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(1000);
    for (int i = 1; i <= 4; i++) drive_sample(1000 - 3 * i);
    check_eq("post_rst_speed", obs_speed, -12);
    stop_run();

    // Stall detection on constant angle
    start_run(500);
    for (int i = 0; i < 28; i++) drive_sample(500);
    check_eq("stall_7", int'(stall), 0);
    for (int i = 0; i < 4; i++) drive_sample(500);
    check_eq("stall_8", int'(stall), 1);
    drive_sample(501); drive_sample(501); drive_sample(501); drive_sample(501);
    check_eq("stall_clear", int'(stall), 0);
    check_eq("stall_clear_speed", obs_speed, 1);
    for (int i = 0; i < 32; i++) drive_sample(501);
    check_eq("stall_again", int'(stall), 1);
    drive_sample(501); drive_sample(501);
    stop_run();
    check_eq("idle_stall", int'(stall), 0);
    check_eq("pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
